mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the processor data bus, in parallel with the data RAM.
- Decodes a small register window for processor stores and loads.
- Buffers stored words in a FIFO and drains them to an external valid/ready output port.
- Synchronizes the 8-bit input port, flags input changes, and returns port and status data on processor loads.

---
 rtl/mmio_port_responder.sv | 187 ++++++++++++++++++
 tb/tb_mmio_port_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_responder
// Brief    : Memory-mapped I/O responder on the processor data bus. Decodes a
//            32-byte register window. Stores to TXDATA go into an output FIFO
//            that drains over a valid/ready port. PortIn is synchronized and
//            change-flagged. Status and port data are returned on loads.
//            Optional macro IO_IRQ_EN adds the CTRL register and a
//            registered interrupt output.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_W      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] OutData,
    output logic        OutValid,
    input  logic        OutReady,
    output logic        Irq
);

    localparam int PTR_W = CNT_W - 1;

    localparam logic [2:0] c_SEL_TXDATA  = 3'd0;
    localparam logic [2:0] c_SEL_STATUS  = 3'd1;
    localparam logic [2:0] c_SEL_PORTIN  = 3'd2;
    localparam logic [2:0] c_SEL_LASTOUT = 3'd3;
`ifdef IO_IRQ_EN
    localparam logic [2:0] c_SEL_CTRL    = 3'd4;
`endif

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_lastOut;
    logic             r_overflow;
    logic             r_inChanged;
    logic [7:0]       r_sync1;
    logic [7:0]       r_sync2;
    logic [7:0]       r_prev;

    logic [2:0]  w_sel;
    logic        w_wrTx;
    logic        w_wrStatus;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [3:0]  w_cntField;
    logic [31:0] w_status;
    logic [31:0] w_ctrlRead;

    // Address decode and FIFO handshake qualifiers
    always_comb begin
        Hit        = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00);
        w_sel      = Address[4:2];
        w_wrTx     = MemWrite && Hit && (w_sel == c_SEL_TXDATA);
        w_wrStatus = MemWrite && Hit && (w_sel == c_SEL_STATUS);
        w_full     = (r_count == CNT_W'(FIFO_DEPTH));
        w_empty    = (r_count == '0);
        // Fullness is judged before the edge, so a same-cycle pop never makes
        // room for a push into a full FIFO.
        w_push     = w_wrTx && !w_full;
        w_pop      = !w_empty && OutReady;
        OutValid   = !w_empty;
        OutData    = w_empty ? 32'd0 : r_mem[r_rdPtr];
        w_cntField = 4'(r_count);
        w_status   = {24'd0, w_cntField, r_overflow, r_inChanged, w_empty, w_full};
    end

    // FIFO storage; no reset needed because OutData is gated while empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= WriteData;
        end
    end

    // FIFO pointers, occupancy, last popped word and overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_lastOut  <= 32'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr   <= r_rdPtr + PTR_W'(1);
                r_lastOut <= OutData;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            // A new overflow event takes priority over a simultaneous clear
            if (w_wrTx && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_wrStatus && WriteData[3]) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Input synchronizer, previous-sample register and change flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= 8'd0;
            r_sync2     <= 8'd0;
            r_prev      <= 8'd0;
            r_inChanged <= 1'b0;
        end else begin
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_sync2 != r_prev) begin
                r_inChanged <= 1'b1;
            end else if (w_wrStatus && WriteData[2]) begin
                r_inChanged <= 1'b0;
            end
        end
    end

`ifdef IO_IRQ_EN
    logic [1:0] r_ctrl;
    logic       r_irq;
    logic       w_wrCtrl;

    // CTRL write strobe and readback value
    always_comb begin
        w_wrCtrl   = MemWrite && Hit && (w_sel == c_SEL_CTRL);
        w_ctrlRead = {30'd0, r_ctrl};
        Irq        = r_irq;
    end

    // CTRL register and registered interrupt request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl <= 2'b00;
            r_irq  <= 1'b0;
        end else begin
            if (w_wrCtrl) begin
                r_ctrl <= WriteData[1:0];
            end
            r_irq <= (r_ctrl[0] && r_inChanged) || (r_ctrl[1] && w_empty);
        end
    end
`else
    // Without the interrupt option CTRL is reserved and Irq is inactive
    always_comb begin
        w_ctrlRead = 32'd0;
        Irq        = 1'b0;
    end
`endif

    // Combinational load data; zero unless a decoded load is in progress
    always_comb begin
        ReadData = 32'd0;
        if (MemRead && Hit) begin
            case (w_sel)
                c_SEL_STATUS:  ReadData = w_status;
                c_SEL_PORTIN:  ReadData = {24'd0, r_sync2};
                c_SEL_LASTOUT: ReadData = r_lastOut;
`ifdef IO_IRQ_EN
                c_SEL_CTRL:    ReadData = w_ctrlRead;
`endif
                default:       ReadData = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_port_responder
// Brief    : Self-checking bench for mmio_port_responder: table-driven bus
//            vectors followed by hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_port_responder;

    localparam logic [31:0] B = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn = 8'd0;
    logic [31:0] OutData;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic        Irq;

    int tests = 0;
    int failed = 0;

    mmio_port_responder #(
        .BASE_ADDR (B),
        .FIFO_DEPTH(4),
        .CNT_W     (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .Hit      (Hit),
        .PortIn   (PortIn),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Irq      (Irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic        rdy;
        logic [31:0] expRd;
        logic        expHit;
        logic        expValid;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[24];

    // Drive one bus cycle at the falling edge; outputs settle before checking
    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic re, input logic rdy);
        @(negedge clk);
        Address   = a;
        WriteData = wd;
        MemWrite  = we;
        MemRead   = re;
        OutReady  = rdy;
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        //           addr      wdata  we  re  rdy  expRd  hit val expData
        vecs[0]  = '{B+32'h4,  32'h0, 0, 1, 0, 32'h02, 1, 0, 32'h0};
        vecs[1]  = '{B,        32'hA, 1, 0, 0, 32'h00, 1, 0, 32'h0};
        vecs[2]  = '{B,        32'hB, 1, 0, 0, 32'h00, 1, 1, 32'hA};
        vecs[3]  = '{B,        32'hC, 1, 0, 0, 32'h00, 1, 1, 32'hA};
        vecs[4]  = '{B,        32'hD, 1, 0, 0, 32'h00, 1, 1, 32'hA};
        vecs[5]  = '{B,        32'hE, 1, 0, 0, 32'h00, 1, 1, 32'hA};
        vecs[6]  = '{B+32'h4,  32'h0, 0, 1, 0, 32'h49, 1, 1, 32'hA};
        vecs[7]  = '{B+32'hC,  32'h0, 0, 1, 1, 32'h00, 1, 1, 32'hA};
        vecs[8]  = '{B+32'hC,  32'h0, 0, 1, 1, 32'h0A, 1, 1, 32'hB};
        vecs[9]  = '{B+32'hC,  32'h0, 0, 1, 1, 32'h0B, 1, 1, 32'hC};
        vecs[10] = '{B+32'hC,  32'h0, 0, 1, 1, 32'h0C, 1, 1, 32'hD};
        vecs[11] = '{B+32'hC,  32'h0, 0, 1, 0, 32'h0D, 1, 0, 32'h0};
        vecs[12] = '{B+32'h4,  32'h0, 0, 1, 0, 32'h0A, 1, 0, 32'h0};
        vecs[13] = '{B+32'h4,  32'h8, 1, 0, 0, 32'h00, 1, 0, 32'h0};
        vecs[14] = '{B+32'h4,  32'h0, 0, 1, 0, 32'h02, 1, 0, 32'h0};
        vecs[15] = '{B+32'h2,  32'h0, 0, 1, 0, 32'h00, 0, 0, 32'h0};
        vecs[16] = '{B+32'h40, 32'h0, 0, 1, 0, 32'h00, 0, 0, 32'h0};
        vecs[17] = '{B+32'h2,  32'h77,1, 0, 0, 32'h00, 0, 0, 32'h0};
        vecs[18] = '{B+32'h40, 32'h77,1, 0, 0, 32'h00, 0, 0, 32'h0};
        vecs[19] = '{B+32'h4,  32'h0, 0, 1, 0, 32'h02, 1, 0, 32'h0};
        vecs[20] = '{B+32'h14, 32'h0, 0, 1, 0, 32'h00, 1, 0, 32'h0};
        vecs[21] = '{B,        32'h0, 0, 1, 0, 32'h00, 1, 0, 32'h0};
        vecs[22] = '{B+32'h1C, 32'h0, 0, 1, 0, 32'h00, 1, 0, 32'h0};
        vecs[23] = '{B+32'h8,  32'h0, 0, 1, 0, 32'h00, 1, 0, 32'h0};

        // Reset
        reset = 1'b1;
        drive(32'd0, 32'd0, 0, 0, 0);
        drive(32'd0, 32'd0, 0, 0, 0);
        reset = 1'b0;
        chk("reset_valid", {31'd0, OutValid}, 32'd0);
        chk("reset_data", OutData, 32'd0);
        chk("reset_irq", {31'd0, Irq}, 32'd0);

        // Table-driven bus vectors
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re, vecs[i].rdy);
            chk($sformatf("v%0d_read", i), ReadData, vecs[i].expRd);
            chk($sformatf("v%0d_hit", i), {31'd0, Hit}, {31'd0, vecs[i].expHit});
            chk($sformatf("v%0d_valid", i), {31'd0, OutValid}, {31'd0, vecs[i].expValid});
            chk($sformatf("v%0d_data", i), OutData, vecs[i].expData);
            chk($sformatf("v%0d_irq", i), {31'd0, Irq}, 32'd0);
        end

        // Push into a full FIFO while it pops in the same cycle: word dropped
        for (int i = 1; i <= 4; i++) begin
            drive(B, i, 1, 0, 0);
        end
        drive(B, 32'h55, 1, 0, 1);
        chk("fullpop_head", OutData, 32'h1);
        drive(B+32'h4, 32'd0, 0, 1, 0);
        chk("fullpop_status", ReadData, 32'h38);
        chk("fullpop_head2", OutData, 32'h2);
        // Push and pop together while not full: count holds
        drive(B, 32'h66, 1, 0, 1);
        drive(B+32'h4, 32'd0, 0, 1, 0);
        chk("pushpop_status", ReadData, 32'h38);
        chk("pushpop_head", OutData, 32'h3);
        drive(B+32'hC, 32'd0, 0, 1, 1);
        chk("drain_3", OutData, 32'h3);
        drive(B+32'hC, 32'd0, 0, 1, 1);
        chk("drain_4", OutData, 32'h4);
        drive(B+32'hC, 32'd0, 0, 1, 1);
        chk("drain_66", OutData, 32'h66);
        drive(B+32'hC, 32'd0, 0, 1, 0);
        chk("drain_valid", {31'd0, OutValid}, 32'd0);
        chk("drain_last", ReadData, 32'h66);
        drive(B+32'h4, 32'h8, 1, 0, 0);
        drive(B+32'h4, 32'd0, 0, 1, 0);
        chk("ovf_clear", ReadData, 32'h02);

        // Input change propagation: PORTIN after 2 edges, in_changed after 3
        PortIn = 8'h3C;
        drive(B+32'h8, 32'd0, 0, 1, 0);
        chk("portin_e1", ReadData, 32'h00);
        drive(B+32'h8, 32'd0, 0, 1, 0);
        chk("portin_e2", ReadData, 32'h3C);
        drive(B+32'h4, 32'd0, 0, 1, 0);
        chk("inchg_e3", ReadData, 32'h06);
        drive(B+32'h4, 32'h4, 1, 0, 0);
        drive(B+32'h4, 32'd0, 0, 1, 0);
        chk("inchg_clear", ReadData, 32'h02);

        // Reset while draining
        drive(B, 32'h11, 1, 0, 0);
        drive(B, 32'h22, 1, 0, 0);
        drive(B+32'hC, 32'd0, 0, 0, 1);
        reset = 1'b1;
        drive(B+32'h4, 32'd0, 0, 1, 1);
        chk("rstmid_status", ReadData, 32'h02);
        chk("rstmid_valid", {31'd0, OutValid}, 32'd0);
        chk("rstmid_data", OutData, 32'd0);
        reset = 1'b0;
        drive(B+32'hC, 32'd0, 0, 1, 0);
        chk("rstmid_last", ReadData, 32'd0);
        PortIn = 8'h00;

`ifdef IO_IRQ_EN
        // Empty-FIFO interrupt: registered, one cycle after the condition
        drive(B+32'h10, 32'h2, 1, 0, 0);
        drive(B+32'h10, 32'd0, 0, 1, 0);
        chk("ctrl_read", ReadData, 32'h2);
        chk("irq_wait", {31'd0, Irq}, 32'd0);
        drive(32'd0, 32'd0, 0, 0, 0);
        chk("irq_set", {31'd0, Irq}, 32'd1);
        drive(B, 32'h33, 1, 0, 0);
        chk("irq_prepush", {31'd0, Irq}, 32'd1);
        drive(32'd0, 32'd0, 0, 0, 0);
        chk("irq_lag", {31'd0, Irq}, 32'd1);
        drive(32'd0, 32'd0, 0, 0, 0);
        chk("irq_clear", {31'd0, Irq}, 32'd0);
`else
        // CTRL offset is reserved: reads 0, writes ignored, Irq stays low
        drive(B+32'h10, 32'h3, 1, 0, 0);
        drive(B+32'h10, 32'd0, 0, 1, 0);
        chk("ctrl_reserved", ReadData, 32'd0);
        chk("ctrl_hit", {31'd0, Hit}, 32'd1);
        drive(32'd0, 32'd0, 0, 0, 0);
        chk("irq_tied", {31'd0, Irq}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
